vga_frame_fetch: RTL and testbench

//  Pixel source for the VGA output stage. Consumes that stage's per-pixel request strobe
//  and vertical sync, reads RGB444 pixels from a double-banked camera frame buffer
//  (sync-read RAM), and returns colour nibbles for the top-left IMG_W x IMG_H window.

---
 rtl/vga_frame_fetch.sv | 160 ++++++++++++++++
 tb/tb_vga_frame_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_fetch.sv
// Purpose : pixel source for the VGA output stage; fetches RGB444 pixels of the top-left
//           IMG_W x IMG_H window from a ping-pong frame buffer and owns the bank swap.
// Latency : request sampled at edge E0 -> RAM read issued at E0 -> colour out at E2.
// Backpressure: none; one output pixel per request cycle, window misses return black.
//
// Ports:
//   iVGA_CLK, iRST_n          pixel clock, async active-low reset
//   iRequest, iVGA_V_SYNC     per-pixel strobe and active-low vsync from the VGA stage
//   iSwapReq / oSwapAck       writer handshake: back bank full / swap taken at frame start
//   oRdBank, oRAM_RD,
//   oRAM_ADDR, iRAM_DATA      sync-read frame buffer port ({B,G,R} data one cycle later)
//   oRed, oGreen, oBlue       colour nibbles
//   oFrameStart               one-cycle pulse per detected vsync falling edge
module vga_frame_fetch #(
    parameter int IMG_W  = 252,
    parameter int IMG_H  = 252,
    parameter int ADDR_W = 16     // IMG_W*IMG_H must fit in 2**ADDR_W words
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iRequest,
    input  logic              iVGA_V_SYNC,
    input  logic              iSwapReq,
    output logic              oSwapAck,
    output logic              oRdBank,
    output logic              oRAM_RD,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    input  logic [11:0]       iRAM_DATA,
    output logic [3:0]        oRed,
    output logic [3:0]        oGreen,
    output logic [3:0]        oBlue,
    output logic              oFrameStart
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {WAIT_FRAME, HBLANK, ACTIVE, VBLANK} state_t;

    state_t             state, stateNext;
    logic               vsD;
    logic               frameStart;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  base;        // row * IMG_W, kept by accumulation
    logic               swapPending;
    logic               rdVld2;      // second stage of the read-valid pipeline
    logic               fetchRead;
    logic               lineEnd;
    logic               doSwap;

    assign frameStart = vsD & ~iVGA_V_SYNC;

    // State register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= WAIT_FRAME;
        else         state <= stateNext;
    end

    // Next-state logic; a frame start overrides everything
    always_comb begin
        stateNext = state;
        if (frameStart) begin
            stateNext = HBLANK;
        end else begin
            unique case (state)
                WAIT_FRAME: stateNext = WAIT_FRAME;
                HBLANK:     if (iRequest) stateNext = ACTIVE;
                ACTIVE:     if (!iRequest)
                                stateNext = (row == ROW_W'(IMG_H - 1)) ? VBLANK : HBLANK;
                VBLANK:     stateNext = VBLANK;
                default:    stateNext = WAIT_FRAME;
            endcase
        end
    end

    // Output/control decode
    always_comb begin
        fetchRead = 1'b0;
        lineEnd   = 1'b0;
        doSwap    = 1'b0;
        if (!frameStart && iRequest && (state == HBLANK || state == ACTIVE))
            fetchRead = (col < COL_W'(IMG_W));
        if (!frameStart && state == ACTIVE && !iRequest)
            lineEnd = 1'b1;
        if (frameStart && (swapPending || iSwapReq))
            doSwap = 1'b1;
    end

    // Position counters and RAM address
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vsD       <= 1'b0;
            col       <= '0;
            row       <= '0;
            base      <= '0;
            oRAM_RD   <= 1'b0;
            oRAM_ADDR <= '0;
        end else begin
            vsD     <= iVGA_V_SYNC;
            oRAM_RD <= fetchRead;
            if (fetchRead)
                oRAM_ADDR <= base + ADDR_W'(col);
            if (frameStart) begin
                col  <= '0;
                row  <= '0;
                base <= '0;
            end else if (lineEnd) begin
                col  <= '0;
                row  <= row + ROW_W'(1);
                base <= base + ADDR_W'(IMG_W);
            end else if (fetchRead) begin
                // stops at IMG_W, so the rest of a long line reads nothing
                col <= col + COL_W'(1);
            end
        end
    end

    // Read data returns one cycle after oRAM_RD; gate it with the delayed valid so
    // every request cycle yields exactly one pixel, black outside the window.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rdVld2 <= 1'b0;
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else begin
            rdVld2 <= oRAM_RD;
            if (rdVld2) begin
                oBlue  <= iRAM_DATA[11:8];
                oGreen <= iRAM_DATA[7:4];
                oRed   <= iRAM_DATA[3:0];
            end else begin
                oBlue  <= '0;
                oGreen <= '0;
                oRed   <= '0;
            end
        end
    end

    // Bank ownership: swaps happen only at frame start so a frame is never torn
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            swapPending <= 1'b0;
            oRdBank     <= 1'b0;
            oSwapAck    <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oFrameStart <= frameStart;
            oSwapAck    <= doSwap;
            if (doSwap) begin
                oRdBank     <= ~oRdBank;
                swapPending <= 1'b0;
            end else begin
                swapPending <= swapPending | iSwapReq;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Purpose : directed self-checking bench for vga_frame_fetch with a sync-read RAM model
//           whose data word equals the low 12 bits of the address.
// Latency : expected pixels are delayed two edges after the request that produced them.
// Backpressure: none; stimulus is applied one pixel clock at a time.
module tb_vga_frame_fetch;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n;
    logic        iRequest;
    logic        iVGA_V_SYNC;
    logic        iSwapReq;
    logic        oSwapAck;
    logic        oRdBank;
    logic        oRAM_RD;
    logic [15:0] oRAM_ADDR;
    logic [11:0] iRAM_DATA;
    logic [3:0]  oRed, oGreen, oBlue;
    logic        oFrameStart;

    int vectors   = 0;
    int miscompares = 0;

    // observation accumulators filled by tick()
    int          pixErr = 0;
    logic [11:0] badObs, badExp;
    int          rdCount = 0, fsCount = 0, ackCount = 0;
    logic [11:0] q1 = '0, q2 = '0;

    vga_frame_fetch #(.IMG_W(252), .IMG_H(252), .ADDR_W(16)) dut (
        .iVGA_CLK   (iVGA_CLK),
        .iRST_n     (iRST_n),
        .iRequest   (iRequest),
        .iVGA_V_SYNC(iVGA_V_SYNC),
        .iSwapReq   (iSwapReq),
        .oSwapAck   (oSwapAck),
        .oRdBank    (oRdBank),
        .oRAM_RD    (oRAM_RD),
        .oRAM_ADDR  (oRAM_ADDR),
        .iRAM_DATA  (iRAM_DATA),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oFrameStart(oFrameStart)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    // sync-read RAM: data = address[11:0], available one edge after the read
    always @(posedge iVGA_CLK) begin
        if (oRAM_RD) iRAM_DATA <= oRAM_ADDR[11:0];
    end

    function automatic logic [11:0] pix(input int row, input int j);
        logic [31:0] a;
        a = 32'(row * 252 + j);
        if (row < 252 && j < 252) return a[11:0];
        return 12'd0;
    endfunction

    // One clock; called at posedge+1, returns at posedge+1. The colour seen after
    // this edge belongs to the request issued two edges earlier.
    task automatic tick(input logic [11:0] expNew);
        @(posedge iVGA_CLK);
        #1;
        if ({oBlue, oGreen, oRed} !== q2) begin
            if (pixErr == 0) begin
                badObs = {oBlue, oGreen, oRed};
                badExp = q2;
            end
            pixErr++;
        end
        q2 = q1;
        q1 = expNew;
        if (oRAM_RD)     rdCount++;
        if (oFrameStart) fsCount++;
        if (oSwapAck)    ackCount++;
    endtask

    task automatic run_line(input int row, input int nReq, input int nBlank);
        for (int j = 0; j < nReq; j++) begin
            iRequest = 1'b1;
            tick(pix(row, j));
        end
        for (int j = 0; j < nBlank; j++) begin
            iRequest = 1'b0;
            tick(12'd0);
        end
    endtask

    task automatic frame_start();
        iRequest    = 1'b0;
        iVGA_V_SYNC = 1'b0;
        tick(12'd0);
        iVGA_V_SYNC = 1'b1;
    endtask

    task automatic clear_counts();
        pixErr = 0; rdCount = 0; fsCount = 0; ackCount = 0;
    endtask

    task automatic test_reset();
        iRST_n = 1'b0; iRequest = 1'b0; iVGA_V_SYNC = 1'b1; iSwapReq = 1'b0;
        repeat (3) @(posedge iVGA_CLK);
        #1;
        vectors++;
        if ({oRdBank, oRAM_RD, oSwapAck, oFrameStart, oBlue, oGreen, oRed, oRAM_ADDR} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got bank=%b rd=%b ack=%b fs=%b rgb=%h addr=%0d, want all 0",
                     oRdBank, oRAM_RD, oSwapAck, oFrameStart, {oBlue, oGreen, oRed}, oRAM_ADDR);
        end
        iRST_n = 1'b1;
        tick(12'd0);
        tick(12'd0);
    endtask

    task automatic test_no_frame_start();
        clear_counts();
        run_line(999, 40, 3);
        run_line(999, 10, 2);
        vectors++;
        if (rdCount !== 0 || fsCount !== 0 || pixErr !== 0) begin
            miscompares++;
            $display("FAIL pre_fs_idle: rd=%0d fs=%0d pixErr=%0d, want 0/0/0", rdCount, fsCount, pixErr);
        end
    endtask

    task automatic test_lines();
        clear_counts();
        tick(12'd0);
        frame_start();
        vectors++;
        if (oFrameStart !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_start_pulse: got %b want 1", oFrameStart);
        end
        tick(12'd0);
        vectors++;
        if (oFrameStart !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_start_width: got %b want 0", oFrameStart);
        end
        // first request: address 0 issued on the same edge
        iRequest = 1'b1;
        tick(pix(0, 0));
        vectors++;
        if (oRAM_RD !== 1'b1 || oRAM_ADDR !== 16'd0) begin
            miscompares++;
            $display("FAIL first_fetch: rd=%b addr=%0d want rd=1 addr=0", oRAM_RD, oRAM_ADDR);
        end
        for (int j = 1; j < 640; j++) tick(pix(0, j));
        iRequest = 1'b0;
        vectors++;
        if (rdCount !== 252 || oRAM_ADDR !== 16'd251) begin
            miscompares++;
            $display("FAIL line0_reads: reads=%0d last_addr=%0d want 252/251", rdCount, oRAM_ADDR);
        end
        for (int j = 0; j < 160; j++) tick(12'd0);
        run_line(1, 640, 160);
        vectors++;
        if (oRAM_ADDR !== 16'd503) begin
            miscompares++;
            $display("FAIL line1_last_addr: got %0d want 503", oRAM_ADDR);
        end
        run_line(2, 640, 160);
        vectors++;
        if (oRAM_ADDR !== 16'd755 || pixErr !== 0) begin
            miscompares++;
            $display("FAIL lines_0_2: addr=%0d pixErr=%0d first bad got %h want %h (want addr 755, 0 errors)",
                     oRAM_ADDR, pixErr, badObs, badExp);
        end
    endtask

    task automatic test_full_frame();
        clear_counts();
        for (int r = 3; r < 252; r++) run_line(r, 253, 2);
        vectors++;
        if (oRAM_ADDR !== 16'd63503 || pixErr !== 0) begin
            miscompares++;
            $display("FAIL window_rows: last_addr=%0d pixErr=%0d got %h want %h (want 63503, 0 errors)",
                     oRAM_ADDR, pixErr, badObs, badExp);
        end
        clear_counts();
        for (int r = 252; r < 262; r++) run_line(r, 253, 2);
        vectors++;
        if (rdCount !== 0 || pixErr !== 0 || oRAM_ADDR !== 16'd63503) begin
            miscompares++;
            $display("FAIL vblank_rows: reads=%0d pixErr=%0d addr=%0d want 0/0/63503", rdCount, pixErr, oRAM_ADDR);
        end
    endtask

    task automatic test_swap_midframe();
        clear_counts();
        frame_start();
        run_line(0, 10, 2);
        iSwapReq = 1'b1; tick(12'd0); iSwapReq = 1'b0;
        run_line(1, 10, 2);
        vectors++;
        if (oRdBank !== 1'b0 || ackCount !== 0) begin
            miscompares++;
            $display("FAIL swap_held_midframe: bank=%b acks=%0d want 0/0", oRdBank, ackCount);
        end
        frame_start();
        vectors++;
        if (oSwapAck !== 1'b1 || oRdBank !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_at_fs: ack=%b bank=%b want 1/1", oSwapAck, oRdBank);
        end
        tick(12'd0);
        vectors++;
        if (oSwapAck !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_width: got %b want 0", oSwapAck);
        end
        clear_counts();
        run_line(0, 10, 2);
        frame_start();
        tick(12'd0);
        vectors++;
        if (oRdBank !== 1'b1 || ackCount !== 0) begin
            miscompares++;
            $display("FAIL fs_no_request: bank=%b acks=%0d want 1/0", oRdBank, ackCount);
        end
    endtask

    task automatic test_swap_coincident();
        run_line(0, 10, 2);
        iSwapReq = 1'b1;
        frame_start();
        iSwapReq = 1'b0;
        vectors++;
        if (oSwapAck !== 1'b1 || oRdBank !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_coincident: ack=%b bank=%b want 1/0", oSwapAck, oRdBank);
        end
        tick(12'd0);
        clear_counts();
        iSwapReq = 1'b1; tick(12'd0); iSwapReq = 1'b0;
        run_line(0, 10, 2);
        iSwapReq = 1'b1; tick(12'd0); iSwapReq = 1'b0;
        run_line(1, 10, 2);
        frame_start();
        tick(12'd0);
        tick(12'd0);
        vectors++;
        if (ackCount !== 1 || oRdBank !== 1'b1) begin
            miscompares++;
            $display("FAIL double_request: acks=%0d bank=%b want 1/1", ackCount, oRdBank);
        end
    endtask

    task automatic test_reset_midline();
        clear_counts();
        for (int r = 0; r < 5; r++) run_line(r, 20, 2);
        iRequest = 1'b1;
        for (int j = 0; j < 100; j++) tick(pix(5, j));
        vectors++;
        if (oRdBank !== 1'b1 || oRAM_ADDR !== 16'd1359) begin
            miscompares++;
            $display("FAIL pre_reset_position: bank=%b addr=%0d want 1/1359", oRdBank, oRAM_ADDR);
        end
        #3 iRST_n = 1'b0;
        #1;
        vectors++;
        if ({oRdBank, oRAM_RD, oSwapAck, oFrameStart, oBlue, oGreen, oRed} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_midline: bank=%b rd=%b rgb=%h want 0/0/000", oRdBank, oRAM_RD, {oBlue, oGreen, oRed});
        end
        @(posedge iVGA_CLK);
        #1;
        q1 = '0; q2 = '0;
        iRST_n = 1'b1;
        clear_counts();
        for (int j = 0; j < 30; j++) tick(12'd0);
        iRequest = 1'b0;
        tick(12'd0);
        vectors++;
        if (rdCount !== 0 || pixErr !== 0) begin
            miscompares++;
            $display("FAIL no_fetch_after_reset: reads=%0d pixErr=%0d want 0/0", rdCount, pixErr);
        end
        frame_start();
        tick(12'd0);
        iRequest = 1'b1;
        tick(pix(0, 0));
        vectors++;
        if (oRAM_RD !== 1'b1 || oRAM_ADDR !== 16'd0 || oRdBank !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_addr: rd=%b addr=%0d bank=%b want 1/0/0", oRAM_RD, oRAM_ADDR, oRdBank);
        end
        for (int j = 1; j < 20; j++) tick(pix(0, j));
        iRequest = 1'b0;
        tick(12'd0);
        tick(12'd0);
        vectors++;
        if (pixErr !== 0) begin
            miscompares++;
            $display("FAIL restart_pixels: %0d errors, first got %h want %h", pixErr, badObs, badExp);
        end
    endtask

    initial begin
        test_reset();
        test_no_frame_start();
        test_lines();
        test_full_frame();
        test_swap_midframe();
        test_swap_coincident();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
